// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution output path.
package conv_pkg;

  localparam int unsigned HALF_EXP  = 5;
  localparam int unsigned HALF_MANT = 10;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  typedef struct packed {
    logic                 sign;
    logic [HALF_EXP-1:0]  exp;
    logic [HALF_MANT-1:0] mant;
  } half_t;

  function automatic int unsigned bias(input int unsigned exp_size);
    return (32'd1 << (exp_size - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned exp_max(input int unsigned exp_size);
    return (32'd1 << exp_size) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_normalize.sv
// Combinational normaliser: leading-zero detect, left shift, exponent adjust
// and zero/overflow/underflow classification of a raw accumulator result.
module fp_normalize
  import conv_pkg::*;
#(
  parameter int unsigned EXP_SIZE  = 5,
  parameter int unsigned MANT_SIZE = 10
) (
  input  logic                 sign,
  input  logic [EXP_SIZE:0]    exponent,
  input  logic [2*MANT_SIZE:0] mant,
  output logic                 norm_sign,
  output logic [EXP_SIZE-1:0]  norm_exp,
  output logic [MANT_SIZE-1:0] norm_mant,
  output logic                 ovf,
  output logic                 uf
);

  localparam int unsigned W   = 2*MANT_SIZE + 1;
  localparam int unsigned LZW = $clog2(W + 1);
  localparam int unsigned EW  = EXP_SIZE + 2;
  localparam logic signed [EW-1:0] EMAX  = EW'(exp_max(EXP_SIZE));
  localparam logic signed [EW-1:0] EZERO = '0;

  logic [LZW-1:0]       lz;
  logic [W-1:0]         shifted;
  logic signed [EW-1:0] e;
  logic                 unused_bits;

  // Highest set bit wins because it is visited last.
  always_comb begin
    lz = LZW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (mant[i]) lz = LZW'(W - 1 - i);
    end
  end

  assign shifted     = mant << lz;
  assign e           = $signed({1'b0, exponent}) - $signed(EW'(lz));
  assign unused_bits = ^{shifted[W-1], shifted[MANT_SIZE-1:0]};

  always_comb begin
    norm_sign = sign;
    norm_exp  = e[EXP_SIZE-1:0];
    norm_mant = shifted[W-2 -: MANT_SIZE];
    ovf       = 1'b0;
    uf        = 1'b0;
    if (mant == '0) begin
      norm_sign = 1'b0;
      norm_exp  = '0;
      norm_mant = '0;
    end else if (e >= EMAX) begin
      norm_exp  = '1;
      norm_mant = '0;
      ovf       = 1'b1;
    end else if (e <= EZERO) begin
      norm_sign = 1'b0;
      norm_exp  = '0;
      norm_mant = '0;
      uf        = 1'b1;
    end
  end

endmodule

// File: rtl/conv_out_writer.sv
// Collects normalised half-precision convolution results into a raster-order
// output map buffer and serves registered reads once the frame is complete.
module conv_out_writer
  import conv_pkg::*;
#(
  parameter int unsigned EXP_SIZE   = 5,
  parameter int unsigned MANT_SIZE  = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OUT_ROWS   = 14,
  parameter int unsigned OUT_COLS   = 14,
  parameter int unsigned ADDR_SIZE  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic                  res_sign,
  input  logic [EXP_SIZE:0]     res_exp,
  input  logic [2*MANT_SIZE:0]  res_mant,
  input  logic                  rd_en,
  input  logic [ADDR_SIZE-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  frame_done,
  output logic                  ovf_flag,
  output logic                  uf_flag
);

  localparam int unsigned DEPTH = OUT_ROWS * OUT_COLS;
  localparam int unsigned CW    = ADDR_SIZE + 1;
  localparam logic [CW-1:0]        DEPTH_CNT = CW'(DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

  state_t state, state_next;
  logic [CW-1:0]        acc_cnt;
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic accept, enter_collect, last_write, last_wr_q, rd_ok;

  logic                 n_sign, n_ovf, n_uf;
  logic [EXP_SIZE-1:0]  n_exp;
  logic [MANT_SIZE-1:0] n_mant;

  logic                 s1_valid, s1_sign, s1_ovf, s1_uf;
  logic [EXP_SIZE-1:0]  s1_exp;
  logic [MANT_SIZE-1:0] s1_mant;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] wr_word;

  fp_normalize #(
    .EXP_SIZE (EXP_SIZE),
    .MANT_SIZE(MANT_SIZE)
  ) u_norm (
    .sign     (res_sign),
    .exponent (res_exp),
    .mant     (res_mant),
    .norm_sign(n_sign),
    .norm_exp (n_exp),
    .norm_mant(n_mant),
    .ovf      (n_ovf),
    .uf       (n_uf)
  );

  assign res_ready  = (state == COLLECT) && (acc_cnt < DEPTH_CNT);
  assign accept     = res_valid && res_ready;
  assign last_write = s1_valid && (wr_ptr == LAST_ADDR);
  assign wr_word    = {s1_sign, s1_exp, s1_mant};
  assign rd_ok      = rd_en && (state == DONE);

  always_comb begin
    state_next    = state;
    enter_collect = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (frame_start) begin
          state_next    = COLLECT;
          enter_collect = 1'b1;
        end
      end
      COLLECT: if (last_write) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // frame_done lags the final write by one edge via last_wr_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc_cnt    <= '0;
      wr_ptr     <= '0;
      s1_valid   <= 1'b0;
      last_wr_q  <= 1'b0;
      frame_done <= 1'b0;
      ovf_flag   <= 1'b0;
      uf_flag    <= 1'b0;
    end else begin
      state     <= state_next;
      s1_valid  <= accept;
      last_wr_q <= last_write;
      if (enter_collect) begin
        acc_cnt    <= '0;
        wr_ptr     <= '0;
        frame_done <= 1'b0;
        ovf_flag   <= 1'b0;
        uf_flag    <= 1'b0;
        last_wr_q  <= 1'b0;
      end else begin
        if (accept) acc_cnt <= acc_cnt + 1'b1;
        if (s1_valid) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (s1_ovf) ovf_flag <= 1'b1;
          if (s1_uf)  uf_flag  <= 1'b1;
        end
        if (last_wr_q) frame_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_sign <= n_sign;
      s1_exp  <= n_exp;
      s1_mant <= n_mant;
      s1_ovf  <= n_ovf;
      s1_uf   <= n_uf;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_valid) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) rd_data <= ({1'b0, rd_addr} >= DEPTH_CNT) ? '0 : mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_conv_out_writer.sv
// Directed self-checking bench for conv_out_writer.
module tb_conv_out_writer;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, frame_start, res_valid, res_ready, res_sign;
  logic [5:0]  res_exp;
  logic [20:0] res_mant;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid, frame_done, ovf_flag, uf_flag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_out_writer #(
    .EXP_SIZE  (5),
    .MANT_SIZE (10),
    .DATA_WIDTH(16),
    .OUT_ROWS  (14),
    .OUT_COLS  (14),
    .ADDR_SIZE (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sign   (res_sign),
    .res_exp    (res_exp),
    .res_mant   (res_mant),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .frame_done (frame_done),
    .ovf_flag   (ovf_flag),
    .uf_flag    (uf_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // 1.0 + k/1024 as a raw 1.20 fixed-point mantissa.
  function automatic logic [20:0] mk(input int k);
    return 21'h100000 | 21'(k << 10);
  endfunction

  function automatic logic [15:0] half(input logic s, input logic [4:0] e, input logic [9:0] m);
    half_t h;
    h.sign = s;
    h.exp  = e;
    h.mant = m;
    return h;
  endfunction

  task automatic send(input logic s, input logic [5:0] e, input logic [20:0] m);
    int guard = 0;
    res_valid = 1'b1;
    res_sign  = s;
    res_exp   = e;
    res_mant  = m;
    while (!res_ready) begin
      guard++;
      if (guard > 50) begin
        check("ready_timeout", res_ready, 1);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_chk(input logic [7:0] a, input logic [15:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    check($sformatf("rd_valid[%0d]", a), rd_valid, 1);
    check($sformatf("rd_data[%0d]", a), rd_data, exp);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"},      res_ready,  0);
    check({pfx, "_rd_data"},    rd_data,    0);
    check({pfx, "_rd_valid"},   rd_valid,   0);
    check({pfx, "_frame_done"}, frame_done, 0);
    check({pfx, "_ovf"},        ovf_flag,   0);
    check({pfx, "_uf"},         uf_flag,    0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] frame_a [6];
    frame_a[0] = 16'h3C00; frame_a[1] = 16'h4200; frame_a[2] = 16'hB800;
    frame_a[3] = 16'h7C00; frame_a[4] = 16'h0000; frame_a[5] = 16'h0000;

    rst = 1'b1; frame_start = 1'b0; res_valid = 1'b0; res_sign = 1'b0;
    res_exp = '0; res_mant = '0; rd_en = 1'b0; rd_addr = '0;
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(1);

    // Frame A: directed normalisation cases, then a throttled fill.
    frame_start = 1'b1;
    idle(1);
    frame_start = 1'b0;
    check("a_ready", res_ready, 1);
    send(1'b0, 6'd15, 21'h100000);
    send(1'b0, 6'd16, 21'h180000);
    send(1'b1, 6'd15, 21'h080000);
    idle(3);
    check("a_ovf_clear", ovf_flag, 0);
    check("a_uf_clear", uf_flag, 0);
    send(1'b0, 6'd31, 21'h100000);
    idle(3);
    check("a_ovf_set", ovf_flag, 1);
    check("a_uf_still_clear", uf_flag, 0);
    send(1'b0, 6'd10, 21'h000001);
    idle(3);
    check("a_uf_set", uf_flag, 1);
    send(1'b1, 6'd15, 21'h000000);
    idle(3);

    rd_en = 1'b1; rd_addr = 8'd0;
    idle(1);
    rd_en = 1'b0;
    check("collect_rd_valid", rd_valid, 0);
    check("collect_rd_data_hold", rd_data, 0);

    for (int k = 6; k < 196; k++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      send(1'b0, 6'd15, mk(k));
    end
    idle(4);
    check("a_frame_done", frame_done, 1);
    check("a_ready_low", res_ready, 0);
    for (int k = 0; k < 6; k++) read_chk(8'(k), frame_a[k]);
    for (int k = 6; k < 196; k++) read_chk(8'(k), 16'h3C00 + 16'(k));
    read_chk(8'd200, 16'h0000);
    idle(1);
    check("rd_valid_pulse", rd_valid, 0);

    // Frame B: back-to-back, frame_done timing.
    frame_start = 1'b1;
    idle(1);
    frame_start = 1'b0;
    check("b_frame_done_clr", frame_done, 0);
    check("b_ovf_clr", ovf_flag, 0);
    check("b_uf_clr", uf_flag, 0);
    check("b_ready", res_ready, 1);
    for (int k = 0; k < 196; k++) send(1'b0, 6'd15, mk(k));
    check("b_ready_after_last", res_ready, 0);
    check("b_done_plus1", frame_done, 0);
    idle(1);
    check("b_done_plus2", frame_done, 0);
    idle(1);
    check("b_done_plus3", frame_done, 1);
    for (int k = 0; k < 196; k++) read_chk(8'(k), 16'h3C00 + 16'(k));

    // Simultaneous frame_start and read in DONE.
    frame_start = 1'b1; rd_en = 1'b1; rd_addr = 8'd5;
    idle(1);
    frame_start = 1'b0; rd_en = 1'b0;
    check("sim_rd_valid", rd_valid, 1);
    check("sim_rd_data", rd_data, 16'h3C05);
    check("sim_frame_done", frame_done, 0);
    check("sim_ready", res_ready, 1);

    // Frame C: aborted by reset at result 50.
    send(1'b0, 6'd31, 21'h100000);
    for (int k = 1; k < 49; k++) send(1'b0, 6'd15, mk(k));
    idle(3);
    check("c_ovf_before_rst", ovf_flag, 1);
    res_valid = 1'b1; res_sign = 1'b0; res_exp = 6'd15; res_mant = mk(49);
    rst = 1'b1;
    idle(1);
    rst = 1'b0; res_valid = 1'b0;
    check_reset_outputs("midrst");

    // Frame D: completes normally after the abort.
    frame_start = 1'b1;
    idle(1);
    frame_start = 1'b0;
    send(1'b1, 6'd15, 21'h000000);
    for (int k = 1; k < 196; k++) send(1'b0, 6'd16, mk(k));
    idle(4);
    check("d_frame_done", frame_done, 1);
    check("d_ovf_absent", ovf_flag, 0);
    check("d_uf_absent", uf_flag, 0);
    read_chk(8'd0, 16'h0000);
    read_chk(8'd1, half(1'b0, 5'd16, 10'd1));
    read_chk(8'd49, 16'h4031);
    read_chk(8'd195, 16'h40C3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
